cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Run/debug sequencer wrapping single_cycle_cpu. It replaces the hand-timed rst/halt stimulus with a state machine that applies a reset window, runs the core, and stops it on a host request, an ecall/ebreak, or a cycle budget. Paused cores support single-stepping. The block reports a stop cause and an executed-cycle count, and sits between the host/testbench and the core's rst/halt inputs.

Parameters:
RST_CYCLES, 4, cycles cpu_rst is held high after start; legal range >=1.
CNT_W, 32, width of the cycle counter and the cycle limit.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous, active-high block reset.
start  in  1  pulse; in IDLE/DONE begins a fresh run; in PAUSED resumes.
halt_req  in  1  host pause request; honoured only in RUN.
step_req  in  1  execute exactly one CPU cycle; honoured only in PAUSED.
cycle_limit  in  CNT_W  run budget in executed cycles, 0 = unlimited; latched on fresh-run start.
cpu_stop_insn  in  1  core is executing ecall/ebreak this cycle.
cpu_rst  out  1  drives core rst.
cpu_halt  out  1  drives core halt; 1 freezes PC and all architectural writes.
busy  out  1  high in RESET, RUN, STEP.
done  out  1  high in DONE.
stop_cause  out  2  0 none, 1 host halt, 2 stop insn, 3 timeout.
cycle_cnt  out  CNT_W  cycles executed since the last fresh start.

Behaviour:
- States: IDLE, RESET, RUN, PAUSED, STEP, DONE. The state, rst counter, cycle_cnt, limit_q and stop_cause are registers. Outputs decode from the state register only; there are no input-to-output combinational paths.
- Reset (rst=1 at an edge): next cycle IDLE, cycle_cnt=0, stop_cause=0, limit_q=0. rst mid-run aborts the run immediately with no drain.
- Output decode:
  - IDLE: cpu_rst=1, cpu_halt=1.
  - RESET: cpu_rst=1, cpu_halt=1.
  - RUN/STEP: cpu_rst=0, cpu_halt=0.
  - PAUSED/DONE: cpu_rst=0, cpu_halt=1 (core state is preserved for inspection).
- IDLE/DONE + start at cycle t:
  - RESET at t+1; cycle_cnt<=0, stop_cause<=0, limit_q<=cycle_limit.
  - RESET lasts exactly RST_CYCLES cycles (t+1..t+RST_CYCLES); RUN begins at t+RST_CYCLES+1.
- Executed cycle: any cycle in RUN or STEP. Each executed cycle, cycle_cnt increments, saturating at all-ones. Cycles in any other state are not counted.
- RUN exit checks, priority high to low, evaluated in each executed cycle:
  - cpu_stop_insn -> DONE, cause 2.
  - limit_q!=0 and (cycle_cnt+1)>=limit_q -> DONE, cause 3.
  - halt_req -> PAUSED, cause 1.
  - The cycle in which an exit fires is itself executed and counted; the new state applies next cycle.
- PAUSED:
  - step_req -> STEP.
  - start -> RUN, cause cleared to 0, cycle_cnt and limit_q kept.
  - Simultaneous start and step_req: step wins.
  - halt_req is ignored. cpu_stop_insn is ignored (core is frozen).
- STEP: one executed cycle, then PAUSED (cause 1). The stop_insn and limit checks apply with the same priority, so STEP can go to DONE.
- start while busy is ignored. step_req outside PAUSED is ignored.
- Timeout with a budget already exceeded on resume: the >= compare stops the core after one executed cycle.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encoding (localparams, 3 bits);
  - stop-cause codes CAUSE_NONE/HOST/INSN/TIMEOUT.
- No sub-module. The FSM, reset down-counter ($clog2(RST_CYCLES+1) bits) and saturating cycle counter stay in one module of about 150-200 lines.

Test Plan:
- Reset, then start at t0 with RST_CYCLES=4 -> cpu_rst=1 for t0+1..t0+4; RUN, busy=1, cpu_halt=0 from t0+5; cycle_cnt=0 at t0+5.
- Run 10 cycles, then halt_req for 1 cycle -> PAUSED next cycle, cpu_halt=1, stop_cause=1, cycle_cnt=11; a later halt_req has no effect.
- In PAUSED, 3 step_req pulses spaced apart -> exactly 3 single-cycle cpu_halt=0 windows, cycle_cnt=14; then start -> RUN, stop_cause=0, counting resumes at 15.
- cycle_limit=20, cpu_stop_insn never asserted -> DONE after the 20th executed cycle, cycle_cnt=20, stop_cause=3, done=1. cycle_limit=20 with cpu_stop_insn in the same 20th cycle -> stop_cause=2.
- rst asserted in RUN with cycle_cnt=7 -> next cycle IDLE, cpu_rst=1, cpu_halt=1, cycle_cnt=0, stop_cause=0, busy=0, done=0.
- DONE + start -> full RESET window again, cycle_cnt cleared; new cycle_limit=0 latched -> runs until cpu_stop_insn, stop_cause=2.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/debug sequencer: FSM states and stop-cause codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReset  = 3'd1,
    StRun    = 3'd2,
    StPaused = 3'd3,
    StStep   = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_HOST    = 2'd1;
  localparam logic [1:0] CAUSE_INSN    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for single_cycle_cpu: reset window, run, pause/step, and stop on
// ecall/ebreak, host request or cycle budget. All outputs decode from registers only.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             cpu_stop_insn,
  output logic             cpu_rst,
  output logic             cpu_halt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_cnt
);
  import cpu_ctrl_pkg::*;

  localparam int unsigned RcW = $clog2(RST_CYCLES + 1);
  localparam logic [RcW-1:0] RcInit = RcW'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [RcW-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [1:0]       cause_q, cause_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   cnt_plus1;
  logic             limit_hit;

  // Compare one bit wider so the budget check stays correct at a saturated count.
  assign cnt_plus1 = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign limit_hit = (limit_q != '0) && (cnt_plus1 >= {1'b0, limit_q});

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StReset;
          rcnt_d  = RcInit;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
          limit_d = cycle_limit;
        end
      end
      StReset: begin
        if (rcnt_q == '0) state_d = StRun;
        else              rcnt_d  = rcnt_q - RcW'(1);
      end
      StRun, StStep: begin
        cnt_d = cnt_inc;
        if (cpu_stop_insn) begin
          state_d = StDone;
          cause_d = CAUSE_INSN;
        end else if (limit_hit) begin
          state_d = StDone;
          cause_d = CAUSE_TIMEOUT;
        end else if (state_q == StStep || halt_req) begin
          state_d = StPaused;
          cause_d = CAUSE_HOST;
        end
      end
      StPaused: begin
        if (step_req) begin
          state_d = StStep;
        end else if (start) begin
          state_d = StRun;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    cpu_rst  = 1'b0;
    cpu_halt = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:   cpu_rst = 1'b1;
      StReset: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      StRun, StStep: begin
        cpu_halt = 1'b0;
        busy     = 1'b1;
      end
      StPaused: ;
      StDone:   done = 1'b1;
      default:  cpu_rst = 1'b1;
    endcase
  end

  assign stop_cause = cause_q;
  assign cycle_cnt  = cnt_q;

endmodule
